ds18b20_driver: RTL and testbench

- 1-Wire master for a single DS18B20 sensor on a 50 MHz clock.
- Runs a continuous loop: reset/presence, Skip ROM (0xCC), Convert T (0x44), wait for conversion, reset/presence, Skip ROM, Read Scratchpad (0xBE), read the 16-bit temperature.
- Converts the reading to sign plus magnitude in units of 0.0001 °C, for a display/UART formatter.
- The DQ line is open-drain; the top level builds the tristate from dq_out and dq_out_en.

---
 rtl/ds18b20_driver.sv | 183 ++++++++++++++++++
 tb/tb_ds18b20_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_driver.sv
// rtl/ds18b20_driver.sv - 1-Wire master polling one DS18B20 and reporting |T| x 10000 with a sign bit.
module ds18b20_driver #(
    parameter int CLK_PER_US = 50,
    parameter int TIME_RST   = 500,
    parameter int TIME_PRE   = 70,
    parameter int TIME_WAIT  = 750000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dq_in,
    output logic        dq_out,
    output logic        dq_out_en,
    output logic        temp_sign,
    output logic [23:0] temp_out,
    output logic        temp_out_vld
);
    localparam int PRE_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int US_MAX = (TIME_WAIT > 2 * TIME_RST) ? TIME_WAIT : 2 * TIME_RST;
    localparam int US_W   = $clog2(((US_MAX > 62) ? US_MAX : 62) + 1);

    localparam logic [PRE_W-1:0] PRE_END     = PRE_W'(CLK_PER_US - 1);
    localparam logic [US_W-1:0]  US_RST      = US_W'(TIME_RST);
    localparam logic [US_W-1:0]  US_RST_END  = US_W'(2 * TIME_RST - 1);
    localparam logic [US_W-1:0]  US_PRE      = US_W'(TIME_RST + TIME_PRE - 1);
    localparam logic [US_W-1:0]  US_WAIT_END = US_W'(TIME_WAIT - 1);
    localparam logic [US_W-1:0]  US_SLOT_END = US_W'(61);
    localparam logic [US_W-1:0]  US_LOW_0    = US_W'(60);
    localparam logic [US_W-1:0]  US_LOW_1    = US_W'(2);
    localparam logic [US_W-1:0]  US_RD_SMP   = US_W'(13);

    typedef enum logic [2:0] {
        S_INIT,
        S_WR_BYTE,
        S_WAIT_CONV,
        S_RD_BITS,
        S_CALC
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [US_W-1:0]   us_q, us_d;
    logic [3:0]        bit_q, bit_d;
    logic              byte_q, byte_d;
    logic              phase_q, phase_d;
    logic              pres_q, pres_d;
    logic [15:0]       raw_q, raw_d;
    logic              temp_sign_q, temp_sign_d;
    logic [23:0]       temp_out_q, temp_out_d;
    logic              temp_out_vld_q, temp_out_vld_d;

    logic              tick;
    logic              drive;
    logic [7:0]        tx_byte;
    logic              tx_bit;
    logic [10:0]       mag;

    always_comb begin
        tick           = (pre_q == PRE_END);
        pre_d          = tick ? '0 : pre_q + PRE_W'(1);
        us_d           = tick ? us_q + US_W'(1) : us_q;
        state_d        = state_q;
        bit_d          = bit_q;
        byte_d         = byte_q;
        phase_d        = phase_q;
        pres_d         = pres_q;
        raw_d          = raw_q;
        temp_sign_d    = temp_sign_q;
        temp_out_d     = temp_out_q;
        temp_out_vld_d = 1'b0;
        drive          = 1'b0;
        // byte_q=0 selects Skip ROM, byte_q=1 the function command of the current pass
        tx_byte        = byte_q ? (phase_q ? 8'hBE : 8'h44) : 8'hCC;
        tx_bit         = tx_byte[bit_q[2:0]];
        mag            = raw_q[15] ? (~raw_q[10:0] + 11'd1) : raw_q[10:0];

        case (state_q)
            S_INIT: begin
                drive = (us_q < US_RST);
                if (tick && us_q == US_PRE) begin
                    pres_d = ~dq_in;
                end
                if (tick && us_q == US_RST_END) begin
                    us_d  = '0;
                    pre_d = '0;
                    if (pres_q) begin
                        state_d = S_WR_BYTE;
                        bit_d   = 4'd0;
                        byte_d  = 1'b0;
                    end
                end
            end
            S_WR_BYTE: begin
                drive = tx_bit ? (us_q < US_LOW_1) : (us_q < US_LOW_0);
                if (tick && us_q == US_SLOT_END) begin
                    us_d  = '0;
                    pre_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        bit_d = 4'd0;
                        if (!byte_q) begin
                            byte_d = 1'b1;
                        end else begin
                            byte_d  = 1'b0;
                            state_d = phase_q ? S_RD_BITS : S_WAIT_CONV;
                        end
                    end
                end
            end
            S_WAIT_CONV: begin
                if (tick && us_q == US_WAIT_END) begin
                    us_d    = '0;
                    pre_d   = '0;
                    phase_d = 1'b1;
                    state_d = S_INIT;
                end
            end
            S_RD_BITS: begin
                drive = (us_q < US_LOW_1);
                if (tick && us_q == US_RD_SMP) begin
                    raw_d = {dq_in, raw_q[15:1]};
                end
                if (tick && us_q == US_SLOT_END) begin
                    us_d  = '0;
                    pre_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        bit_d   = 4'd0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                temp_sign_d    = raw_q[15];
                temp_out_d     = {13'd0, mag} * 24'd625;
                temp_out_vld_d = 1'b1;
                phase_d        = 1'b0;
                us_d           = '0;
                pre_d          = '0;
                state_d        = S_INIT;
            end
            default: begin
                us_d    = '0;
                pre_d   = '0;
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= S_INIT;
            pre_q          <= '0;
            us_q           <= '0;
            bit_q          <= 4'd0;
            byte_q         <= 1'b0;
            phase_q        <= 1'b0;
            pres_q         <= 1'b0;
            raw_q          <= 16'd0;
            temp_sign_q    <= 1'b0;
            temp_out_q     <= 24'd0;
            temp_out_vld_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_q          <= pre_d;
            us_q           <= us_d;
            bit_q          <= bit_d;
            byte_q         <= byte_d;
            phase_q        <= phase_d;
            pres_q         <= pres_d;
            raw_q          <= raw_d;
            temp_sign_q    <= temp_sign_d;
            temp_out_q     <= temp_out_d;
            temp_out_vld_q <= temp_out_vld_d;
        end
    end

    // Reset releases the bus in the same cycle it is raised, not one edge later.
    assign dq_out       = 1'b0;
    assign dq_out_en    = drive & ~rst_n;
    assign temp_sign    = temp_sign_q;
    assign temp_out     = temp_out_q;
    assign temp_out_vld = temp_out_vld_q;
endmodule

// File: tb/tb_ds18b20_driver.sv
// tb/tb_ds18b20_driver.sv - bench for ds18b20_driver with a timing-level DS18B20 slave model.
module tb_ds18b20_driver;
    localparam int CLK    = 2;
    localparam int T_RST  = 100;
    localparam int T_PRE  = 30;
    localparam int T_WAIT = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        dq_in;
    logic        dq_out;
    logic        dq_out_en;
    logic        temp_sign;
    logic [23:0] temp_out;
    logic        temp_out_vld;
    logic        slave_low = 1'b0;

    assign dq_in = ~(dq_out_en | slave_low);

    always #10 clk = ~clk;

    ds18b20_driver #(
        .CLK_PER_US(CLK),
        .TIME_RST  (T_RST),
        .TIME_PRE  (T_PRE),
        .TIME_WAIT (T_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dq_in       (dq_in),
        .dq_out      (dq_out),
        .dq_out_en   (dq_out_en),
        .temp_sign   (temp_sign),
        .temp_out    (temp_out),
        .temp_out_vld(temp_out_vld)
    );

    int          vectors = 0;
    int          miscompares = 0;

    // Slave model: decodes master low pulses by width, answers presence and read slots.
    int          cyc = 0;
    bit          prev_en = 1'b0;
    int          fall_t = 0;
    int          rise_t = 0;
    int          len = 0;
    int          lo_from = -1;
    int          lo_to = -1;
    int          mode = 0;
    logic [7:0]  sh = 8'd0;
    int          nbits = 0;
    logic [7:0]  rx_q[$];
    logic [15:0] tx_word = 16'd0;
    int          tx_idx = 0;
    bit          present_en = 1'b0;
    int          resets_seen = 0;
    int          short_pulses = 0;
    int          bad_width = 0;
    int          vld_count = 0;
    bit          after_44 = 1'b0;
    int          conv_gap = -1;

    always @(negedge clk) begin
        cyc++;
        if (temp_out_vld) vld_count++;
        if (dq_out_en && !prev_en) begin
            fall_t = cyc;
            if (after_44) begin
                conv_gap = cyc - rise_t;
                after_44 = 1'b0;
            end
            if (mode == 2) begin
                if (tx_idx < 16 && !tx_word[tx_idx]) begin
                    lo_from = cyc;
                    lo_to   = cyc + 30 * CLK;
                end
                tx_idx++;
            end
        end else if (!dq_out_en && prev_en) begin
            rise_t = cyc;
            len    = cyc - fall_t;
            if (len >= 80 * CLK) begin
                resets_seen++;
                mode  = 1;
                nbits = 0;
                if (present_en) begin
                    lo_from = cyc + 10 * CLK;
                    lo_to   = cyc + 60 * CLK;
                end
            end else begin
                short_pulses++;
                if (mode == 1) begin
                    if (len != 2 * CLK && len != 60 * CLK) bad_width++;
                    sh = {(len < 15 * CLK), sh[7:1]};
                    nbits++;
                    if (nbits == 8) begin
                        rx_q.push_back(sh);
                        nbits = 0;
                        if (sh == 8'h44) after_44 = 1'b1;
                        if (sh == 8'hBE) begin
                            mode   = 2;
                            tx_idx = 0;
                        end
                    end
                end
            end
        end
        prev_en   = dq_out_en;
        slave_low = (cyc >= lo_from) && (cyc < lo_to);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic wait_vld(input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (temp_out_vld) ok = 1'b1;
        end
    endtask

    task automatic release_and_measure(output int low_len);
        @(posedge clk);
        #1 rst_n = 1'b0;
        low_len = 0;
        @(negedge clk);
        while (dq_out_en && low_len < 10 * T_RST * CLK) begin
            low_len++;
            @(negedge clk);
        end
    endtask

    task automatic run_temp(input string tag, input logic [15:0] raw,
                            input bit exp_sign, input int exp_temp);
        bit          ok;
        logic [31:0] seq;
        tx_word = raw;
        rx_q.delete();
        wait_vld(12000, ok);
        check({tag, " vld_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            seq = (rx_q.size() == 4) ? {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} : 32'd0;
            check({tag, " cmd_bytes"}, seq, 32'hCC44CCBE);
            check({tag, " sign"}, 32'(temp_sign), 32'(exp_sign));
            check({tag, " temp"}, 32'(temp_out), 32'(exp_temp));
            @(negedge clk);
            check({tag, " vld_one_cycle"}, 32'(temp_out_vld), 32'd0);
        end
    endtask

    function automatic int ref_temp(input logic [15:0] raw);
        int v;
        v = int'(raw);
        if (raw[15]) v = 65536 - v;
        return (v % 2048) * 625;
    endfunction

    initial begin
        int   rlen;
        int   n;
        int   v;
        logic [15:0] r;

        rst_n      = 1'b1;
        present_en = 1'b0;
        repeat (20) @(negedge clk);
        check("rst dq_out_en", 32'(dq_out_en), 32'd0);
        check("rst dq_out", 32'(dq_out), 32'd0);
        check("rst temp_sign", 32'(temp_sign), 32'd0);
        check("rst temp_out", 32'(temp_out), 32'd0);
        check("rst vld", 32'(temp_out_vld), 32'd0);

        release_and_measure(rlen);
        check("init low cycles", 32'(rlen), 32'(T_RST * CLK));

        repeat (3 * 2 * T_RST * CLK) @(negedge clk);
        check("nodev init repeats", 32'(resets_seen >= 3), 32'd1);
        check("nodev no slots", 32'(short_pulses), 32'd0);
        check("nodev no vld", 32'(vld_count), 32'd0);

        present_en = 1'b1;
        run_temp("t25", 16'h0191, 1'b0, 250625);
        check("conv wait gap", 32'(conv_gap), 32'((2 + T_WAIT) * CLK));
        run_temp("tm10", 16'hFF5E, 1'b1, 101250);

        for (int i = 0; i < 2; i++) begin
            v = int'($urandom_range(0, 2880)) - 880;
            r = 16'(v);
            run_temp("rand_real", r, v < 0, (v < 0 ? -v : v) * 625);
        end
        r = 16'($urandom);
        run_temp("rand_raw", r, r[15], ref_temp(r));

        run_temp("t125", 16'h07D0, 1'b0, 1250000);
        check("slot widths", 32'(bad_width), 32'd0);

        n = 0;
        while (!(mode == 2 && tx_idx >= 4 && dq_out_en) && n < 12000) begin
            @(negedge clk);
            n++;
        end
        check("reached read slot", 32'(mode == 2 && dq_out_en), 32'd1);
        rst_n = 1'b1;
        #1;
        check("abort releases line", 32'(dq_out_en), 32'd0);
        repeat (5) @(negedge clk);
        check("abort temp_out", 32'(temp_out), 32'd0);
        check("abort temp_sign", 32'(temp_sign), 32'd0);
        check("abort vld", 32'(temp_out_vld), 32'd0);
        release_and_measure(rlen);
        check("restart init low", 32'(rlen), 32'(T_RST * CLK));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
